// File: rtl/fifo2linebuf_pkg.sv
// rtl/fifo2linebuf_pkg.sv - word layout, state encoding and widths shared by fifo2linebuf
package fifo2linebuf_pkg;

  localparam int WORD_W  = 29;
  localparam int RSV_BIT = 28;
  localparam int SEG_BIT = 27;
  localparam int Y_MSB   = 26;
  localparam int Y_LSB   = 16;
  localparam int PIX_MSB = 15;
  localparam int PIX_LSB = 0;

  localparam int Y_W    = 11;
  localparam int PIX_W  = 16;
  localparam int X_W    = 11;
  localparam int LEN_W  = 11;
  localparam int BANK_W = 1;
  localparam int ADDR_W = BANK_W + X_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_BANK = 2'd2
  } state_t;

  // x is kept one bit wider than the RAM column so LINE_PIXELS=2048 stays representable
  function automatic logic [X_W:0] seg_base(input logic seg, input logic [X_W:0] seg_pixels);
    return seg ? seg_pixels : '0;
  endfunction

endpackage

// File: rtl/fifo2linebuf_if.sv
// rtl/fifo2linebuf_if.sv - FIFO head, line-RAM write and line-close signals of fifo2linebuf
interface fifo2linebuf_if;
  import fifo2linebuf_pkg::*;

  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [1:0]        bank_free;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              line_done;
  logic [Y_W-1:0]    line_y;
  logic              line_bank;
  logic [LEN_W-1:0]  line_len;
  logic              err_ovf;

  modport master (
    input  fifo_dout, fifo_empty, bank_free,
    output fifo_rd_en, wr_en, wr_addr, wr_data,
    output line_done, line_y, line_bank, line_len, err_ovf
  );

  modport slave (
    output fifo_dout, fifo_empty, bank_free,
    input  fifo_rd_en, wr_en, wr_addr, wr_data,
    input  line_done, line_y, line_bank, line_len, err_ovf
  );
endinterface

// File: rtl/fifo2linebuf.sv
// rtl/fifo2linebuf.sv - packs FWFT video FIFO words into a two-bank line RAM (LINEBUF_STATS_EN adds drop_cnt)
module fifo2linebuf
  import fifo2linebuf_pkg::*;
#(
  parameter SEG_PIXELS  = 11'd600,
  parameter LINE_PIXELS = 11'd1200,
  parameter IDLE_FLUSH  = 16'd4096
) (
  input  logic          clk125,
  input  logic          sys_rst,
  fifo2linebuf_if.master bus
`ifdef LINEBUF_STATS_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam logic [X_W:0] SEG_PIX    = 12'(SEG_PIXELS);
  localparam logic [X_W:0] LINE_MAX   = 12'(LINE_PIXELS);
  localparam logic [15:0]  FLUSH_LAST = 16'(IDLE_FLUSH - 1);

  state_t           state;
  logic [X_W:0]     x;
  logic [Y_W-1:0]   cur_y;
  logic             seg;
  logic             cur_bank;
  logic             last_bank;
  logic             has_last;
  logic [1:0]       claim;
  logic [LEN_W-1:0] len;
  logic [15:0]      idle_cnt;

  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [PIX_W-1:0]  wr_data_r;
  logic              line_done_r;
  logic [Y_W-1:0]    line_y_r;
  logic              line_bank_r;
  logic [LEN_W-1:0]  line_len_r;
  logic              err_ovf_r;

  logic [Y_W-1:0]   head_y;
  logic             head_seg;
  logic [PIX_W-1:0] head_pix;
  logic             unused_rsv;
  logic [1:0]       avail;
  logic             pref;
  logic             pick;
  logic             accept;
  logic             ovf;
  logic             close_line;
  logic [X_W:0]     x_use;

  assign head_y     = bus.fifo_dout[Y_MSB:Y_LSB];
  assign head_seg   = bus.fifo_dout[SEG_BIT];
  assign head_pix   = bus.fifo_dout[PIX_MSB:PIX_LSB];
  assign unused_rsv = bus.fifo_dout[RSV_BIT];

  // Alternate banks so the consumer can still read the previous line; bank 0 first after reset
  assign avail = bus.bank_free & ~claim;
  assign pref  = has_last ? ~last_bank : 1'b0;
  assign pick  = avail[pref] ? pref : ~pref;

  assign accept     = (state == FILL) && !bus.fifo_empty && (head_y == cur_y);
  assign x_use      = (head_seg != seg) ? seg_base(head_seg, SEG_PIX) : x;
  assign ovf        = accept && (x_use >= LINE_MAX);
  assign close_line = (state == FILL) &&
                      (bus.fifo_empty ? (idle_cnt == FLUSH_LAST) : (head_y != cur_y));

  assign bus.fifo_rd_en = accept;
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.line_done  = line_done_r;
  assign bus.line_y     = line_y_r;
  assign bus.line_bank  = line_bank_r;
  assign bus.line_len   = line_len_r;
  assign bus.err_ovf    = err_ovf_r;

  always_ff @(posedge clk125 or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      x           <= '0;
      cur_y       <= '0;
      seg         <= 1'b0;
      cur_bank    <= 1'b0;
      last_bank   <= 1'b0;
      has_last    <= 1'b0;
      claim       <= 2'b00;
      len         <= '0;
      idle_cnt    <= '0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      line_done_r <= 1'b0;
      line_y_r    <= '0;
      line_bank_r <= 1'b0;
      line_len_r  <= '0;
      err_ovf_r   <= 1'b0;
    end else begin
      wr_en_r     <= 1'b0;
      line_done_r <= 1'b0;
      err_ovf_r   <= 1'b0;
      case (state)
        IDLE, WAIT_BANK: begin
          if (bus.fifo_empty) begin
            state <= IDLE;
          end else if (|avail) begin
            cur_bank  <= pick;
            last_bank <= pick;
            has_last  <= 1'b1;
            claim     <= pick ? 2'b10 : 2'b01;
            cur_y     <= head_y;
            seg       <= head_seg;
            x         <= seg_base(head_seg, SEG_PIX);
            len       <= '0;
            idle_cnt  <= '0;
            state     <= FILL;
          end else begin
            state <= WAIT_BANK;
          end
        end
        FILL: begin
          if (close_line) begin
            line_done_r <= 1'b1;
            line_y_r    <= cur_y;
            line_bank_r <= cur_bank;
            line_len_r  <= len;
            claim       <= 2'b00;
            state       <= IDLE;
          end else if (bus.fifo_empty) begin
            idle_cnt <= idle_cnt + 16'd1;
          end else begin
            idle_cnt <= '0;
            seg      <= head_seg;
            if (ovf) begin
              err_ovf_r <= 1'b1;
              x         <= LINE_MAX;
            end else begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= {cur_bank, x_use[X_W-1:0]};
              wr_data_r <= head_pix;
              x         <= x_use + 12'd1;
              if (len != '1) len <= len + 11'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINEBUF_STATS_EN
  always_ff @(posedge clk125 or posedge sys_rst) begin
    if (sys_rst) begin
      drop_cnt <= '0;
    end else if (ovf && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo2linebuf.sv
// tb/tb_fifo2linebuf.sv - directed bench for fifo2linebuf with a queue-backed FWFT FIFO
module tb_fifo2linebuf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  fifo2linebuf_if bus();
`ifdef LINEBUF_STATS_EN
  logic [15:0] drop_cnt;
`endif

  fifo2linebuf dut (
    .clk125  (clk),
    .sys_rst (rst),
    .bus     (bus)
`ifdef LINEBUF_STATS_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [28:0] fq[$];
  logic [11:0] wa[$];
  logic [15:0] wd[$];
  int cyc = 0, last_wr_cyc = 0, ld_gap = 0, ld_cnt = 0, ovf_cnt = 0, pop_cnt = 0, rd_viol = 0;
  logic [10:0] ld_y, ld_len;
  logic        ld_bank;
  logic        last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_head();
    if (fq.size() == 0) begin
      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = '0;
    end else begin
      bus.fifo_empty = 1'b0;
      bus.fifo_dout  = fq[0];
    end
  endtask

  function automatic void push(input logic seg, input logic [10:0] y, input logic [15:0] pix);
    fq.push_back({1'b0, seg, y, pix});
  endfunction

  task automatic tick();
    logic popped;
    @(negedge clk);
    cyc++;
    last_rd = bus.fifo_rd_en;
    if (bus.fifo_rd_en && bus.fifo_empty) rd_viol++;
    popped = bus.fifo_rd_en && !bus.fifo_empty;
    if (popped) pop_cnt++;
    if (bus.wr_en) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
      last_wr_cyc = cyc;
    end
    if (bus.line_done) begin
      ld_cnt++;
      ld_y    = bus.line_y;
      ld_len  = bus.line_len;
      ld_bank = bus.line_bank;
      ld_gap  = cyc - last_wr_cyc;
    end
    if (bus.err_ovf) ovf_cnt++;
    @(posedge clk);
    #1;
    if (popped) void'(fq.pop_front());
    drive_head();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int budget, input string tag);
    int k = 0;
    while (fq.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_drain_timeout"}, 32'(fq.size()), 0);
    run(3);
  endtask

  task automatic wait_ld(input int target, input int budget, input string tag);
    int k = 0;
    while (ld_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_line_done_timeout"}, 32'(ld_cnt >= target), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"},     32'(bus.fifo_rd_en), 0);
    check({tag, "_wr_en"},     32'(bus.wr_en), 0);
    check({tag, "_wr_addr"},   32'(bus.wr_addr), 0);
    check({tag, "_wr_data"},   32'(bus.wr_data), 0);
    check({tag, "_line_done"}, 32'(bus.line_done), 0);
    check({tag, "_line_y"},    32'(bus.line_y), 0);
    check({tag, "_line_bank"}, 32'(bus.line_bank), 0);
    check({tag, "_line_len"},  32'(bus.line_len), 0);
    check({tag, "_err_ovf"},   32'(bus.err_ovf), 0);
`ifdef LINEBUF_STATS_EN
    check({tag, "_drop_cnt"},  32'(drop_cnt), 0);
`endif
  endtask

  initial begin
    int bad;
    int p0;
    int ld0;

    bus.bank_free = 2'b11;
    drive_head();
    run(3);
    check_zero("reset");
    rst = 1'b0;
    run(2);

    // one full segment of y=5 into bank 0
    for (int i = 0; i < 600; i++) push(1'b0, 11'd5, 16'(16'h1000 + i));
    drive_head();
    drain(2000, "s1");
    check("s1_count", 32'(wa.size()), 600);
    bad = 0;
    for (int i = 0; i < 600; i++)
      if (wa[i] !== 12'(i) || wd[i] !== 16'(16'h1000 + i)) bad++;
    check("s1_order", bad, 0);
    check("s1_first_addr", 32'(wa[0]), 'h000);
    check("s1_last_addr", 32'(wa[599]), 'h257);
    check("s1_no_line_done", ld_cnt, 0);

    // second segment of y=5 continues at x=600, then y=6 closes the line
    for (int i = 0; i < 600; i++) push(1'b1, 11'd5, 16'(16'h2000 + i));
    push(1'b0, 11'd6, 16'h6000);
    drive_head();
    wait_ld(1, 3000, "s2");
    check("s2_line_y", 32'(ld_y), 5);
    check("s2_line_len", 32'(ld_len), 1200);
    check("s2_line_bank", 32'(ld_bank), 0);
    check("s2_after_last_wr", 32'(ld_gap >= 1), 1);
    check("s2_seg1_start", 32'(wa[600]), 'h258);
    bad = 0;
    for (int i = 0; i < 600; i++)
      if (wa[600 + i] !== 12'(600 + i) || wd[600 + i] !== 16'(16'h2000 + i)) bad++;
    check("s2_order", bad, 0);
    drain(100, "s2b");
    check("s2_y6_count", 32'(wa.size()), 1201);
    check("s2_y6_other_bank", 32'(wa[1200]), 'h800);

    // y=7 with no bank free must not be popped
    bus.bank_free = 2'b00;
    push(1'b0, 11'd7, 16'h7000);
    drive_head();
    p0 = pop_cnt;
    run(20);
    check("s3_y6_closed", ld_cnt, 2);
    check("s3_y6_len", 32'(ld_len), 1);
    check("s3_y6_bank", 32'(ld_bank), 1);
    check("s3_no_pop", pop_cnt - p0, 0);
    check("s3_rd_en_low", 32'(last_rd), 0);
    check("s3_word_kept", 32'(fq.size()), 1);
    bus.bank_free = 2'b01;
    push(1'b0, 11'd7, 16'h7001);
    push(1'b0, 11'd7, 16'h7002);
    drive_head();
    drain(100, "s3");
    check("s3_count", 32'(wa.size()), 1204);
    check("s3_resume_addr", 32'(wa[1201]), 'h000);
    check("s3_resume_data", 32'(wd[1201]), 'h7000);
    check("s3_third_addr", 32'(wa[1203]), 'h002);

    // y=8: 500 + 700 words overruns the line by 100; y=9 follows with 10 words
    bus.bank_free = 2'b11;
    for (int i = 0; i < 500; i++) push(1'b0, 11'd8, 16'(16'h8000 + i));
    for (int i = 0; i < 700; i++) push(1'b1, 11'd8, 16'(16'h9000 + i));
    for (int i = 0; i < 10; i++) push(1'b0, 11'd9, 16'(16'hA000 + i));
    drive_head();
    wait_ld(4, 4000, "s4");
    check("s4_line_y", 32'(ld_y), 8);
    check("s4_line_len", 32'(ld_len), 1100);
    check("s4_line_bank", 32'(ld_bank), 1);
    check("s4_ovf_pulses", ovf_cnt, 100);
    check("s4_last_addr", 32'(wa[2303]), 'hCAF);
`ifdef LINEBUF_STATS_EN
    check("s4_drop_cnt", 32'(drop_cnt), 100);
`endif

    // y=9 is closed by the idle flush
    wait_ld(5, 5000, "s5");
    check("s5_line_y", 32'(ld_y), 9);
    check("s5_line_len", 32'(ld_len), 10);
    check("s5_line_bank", 32'(ld_bank), 0);
    check("s5_flush_delay", ld_gap, 4096);
    check("s5_last_addr", 32'(wa[2313]), 'h009);

    // reset in the middle of y=10
    ld0 = ld_cnt;
    for (int i = 0; i < 20; i++) push(1'b0, 11'd10, 16'(16'hB000 + i));
    drive_head();
    run(8);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    fq.delete();
    drive_head();
    run(3);
    rst = 1'b0;
    run(20);
    check("s6_no_line_done", ld_cnt - ld0, 0);
    check("rd_en_while_empty", rd_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
